fsm_seq_gen: RTL

- Serial pattern transmitter; the counterpart of the overlapping sequence detectors (e.g. the 1011010 detector).
- Latches a WIDTH-bit pattern on a start handshake and drives it MSB-first on a 1-bit serial line, one bit per clock.
- Can send the pattern back-to-back or with a configurable idle gap, a programmable number of times.
- Drives detector inputs in benches and serial links in the design.

---
 rtl/fsm_seq_gen.sv | 117 +++++++++++
 1 files changed

// File: rtl/fsm_seq_gen.sv
// Serial pattern transmitter: latches a WIDTH-bit pattern on start and shifts it
// out MSB-first, repeat_cnt+1 times, with an optional idle gap between repeats.
module fsm_seq_gen #(
  parameter int unsigned WIDTH      = 7,
  parameter int unsigned GAP_CYCLES = 0,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       repeat_cnt,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   IW       = $clog2(WIDTH);
  localparam int unsigned   GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IW-1:0] IDX_MSB  = IW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [3:0]       rep_q, rep_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d   = pattern;
          rep_d   = repeat_cnt;
          idx_d   = IDX_MSB;
          gap_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else if (rep_q != '0) begin
          rep_d   = rep_q - 1'b1;
          idx_d   = IDX_MSB;
          gap_d   = '0;
          state_d = (GAP_CYCLES > 0) ? GAP : SHIFT;
        end else begin
          state_d = DONE;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = SHIFT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      DONE: begin
        idx_d   = '0;
        rep_d   = '0;
        gap_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register on the same edge.
    out_d   = (state_d == SHIFT) ? pat_d[idx_d] : IDLE_LEVEL;
    valid_d = (state_d == SHIFT);
    busy_d  = (state_d == SHIFT) || (state_d == GAP);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      out_q   <= IDLE_LEVEL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
